// File: rtl/drop_sched_pkg.sv
// drop_sched_pkg
//   Shared definitions for the drop_sched control-channel scheduler:
//   default parameter values, FSM state encodings and the decision type.
//   Imported by drop_sched and drop_sched_ack_sync.
package drop_sched_pkg;

  // Default widths / depths for the scheduler.
  localparam int DEF_CW          = 8;   // pass_len/drop_len/position width
  localparam int DEF_SYNC_STAGES = 2;   // actl_i synchronizer depth
  localparam int DEF_SW          = 16;  // statistics counter width

  // FSM states (plain constants so the encoding is fixed and visible).
  localparam logic [1:0] IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] REQ  = 2'd1;  // one rail high, waiting for ack
  localparam logic [1:0] REL  = 2'd2;  // rails low, waiting for ack release

  // Per-token decision.
  typedef enum logic {
    DEC_PASS = 1'b0,  // token goes to the output (ctl_a)
    DEC_DROP = 1'b1   // token goes to the sink (ctl_b)
  } decision_t;

endpackage

// File: rtl/drop_sched_ack_sync.sv
// drop_sched_ack_sync
//   Multi-flop synchronizer bringing the asynchronous control-channel
//   acknowledge into the clk domain. Reset clears every stage to 0.
// Ports:
//   clk  in  1  clock, rising edge
//   rst  in  1  asynchronous, active-low reset
//   d    in  1  asynchronous input (actl_i)
//   q    out 1  synchronized output (ack_s), STAGES flops after d
module drop_sched_ack_sync
  import drop_sched_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  // Plain shift chain; bit 0 is the metastability-catching stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/drop_sched.sv
// drop_sched
//   Clocked scheduler driving the dual-rail 4-phase control channel of a
//   conditional sink. Repeats a pattern of sh_pass PASS tokens (ctl_a)
//   followed by sh_drop DROP tokens (ctl_b); one decision per completed
//   control handshake. Lengths are sampled at the start of each period.
// Optional feature macro: DROP_SCHED_STATS_EN
//   When defined, adds the SW parameter and the pass_cnt/drop_cnt
//   saturating statistics outputs.
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   asynchronous, active-low reset
//   en        in   1   start/continue issuing decisions
//   pass_len  in   CW  tokens passed per period
//   drop_len  in   CW  tokens dropped per period
//   ctl_a     out  1   control rail "pass" (registered)
//   ctl_b     out  1   control rail "drop" (registered)
//   actl_i    in   1   control-channel ack from datapath (asynchronous)
//   busy      out  1   handshake in progress (state != IDLE)
//   pass_cnt  out  SW  passed-token count (DROP_SCHED_STATS_EN only)
//   drop_cnt  out  SW  dropped-token count (DROP_SCHED_STATS_EN only)
module drop_sched
  import drop_sched_pkg::*;
#(
  parameter int CW          = DEF_CW,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef DROP_SCHED_STATS_EN
  ,
  parameter int SW          = DEF_SW
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] pass_len,
  input  logic [CW-1:0] drop_len,
  output logic          ctl_a,
  output logic          ctl_b,
  input  logic          actl_i,
  output logic          busy
`ifdef DROP_SCHED_STATS_EN
  ,
  output logic [SW-1:0] pass_cnt,
  output logic [SW-1:0] drop_cnt
`endif
);

  localparam logic [CW-1:0] POS_ONE    = CW'(1);
  localparam logic [CW:0]   PERIOD_ONE = (CW + 1)'(1);

  logic ack_s;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] pos_reg, pos_next;
  logic [CW-1:0] sh_pass_reg, sh_pass_next;
  logic [CW-1:0] sh_drop_reg, sh_drop_next;
  logic          ctl_a_reg, ctl_a_next;
  logic          ctl_b_reg, ctl_b_next;

  logic [CW-1:0] eff_pass;
  logic [CW-1:0] eff_drop;
  logic          dec_pass;
  logic [CW:0]   period;
  logic          period_end;

  drop_sched_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (actl_i),
    .q   (ack_s)
  );

  // At the start of a period (pos==0) the lengths about to be captured
  // are the ones that decide this token, so look through to the inputs.
  assign eff_pass = (pos_reg == '0) ? pass_len : sh_pass_reg;
  assign eff_drop = (pos_reg == '0) ? drop_len : sh_drop_reg;

  // Both lengths zero degenerates to "pass everything".
  assign dec_pass = (pos_reg < eff_pass) ||
                    ((eff_pass == '0) && (eff_drop == '0));

  // Period is one bit wider so pass_len+drop_len cannot overflow.
  assign period     = {1'b0, sh_pass_reg} + {1'b0, sh_drop_reg};
  assign period_end = (period == '0) || ({1'b0, pos_reg} == (period - PERIOD_ONE));

  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    sh_pass_next = sh_pass_reg;
    sh_drop_next = sh_drop_reg;
    ctl_a_next   = ctl_a_reg;
    ctl_b_next   = ctl_b_reg;

    case (state_reg)
      IDLE: begin
        // A stale ack (ack_s still high) blocks the next request.
        if (en && !ack_s) begin
          if (pos_reg == '0) begin
            sh_pass_next = pass_len;
            sh_drop_next = drop_len;
          end
          ctl_a_next = dec_pass;
          ctl_b_next = !dec_pass;
          state_next = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          ctl_a_next = 1'b0;
          ctl_b_next = 1'b0;
          state_next = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          pos_next   = period_end ? '0 : (pos_reg + POS_ONE);
          state_next = IDLE;
        end
      end
      default: begin
        ctl_a_next = 1'b0;
        ctl_b_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pos_reg     <= '0;
      sh_pass_reg <= '0;
      sh_drop_reg <= '0;
      ctl_a_reg   <= 1'b0;
      ctl_b_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      sh_pass_reg <= sh_pass_next;
      sh_drop_reg <= sh_drop_next;
      ctl_a_reg   <= ctl_a_next;
      ctl_b_reg   <= ctl_b_next;
    end
  end

  assign ctl_a = ctl_a_reg;
  assign ctl_b = ctl_b_reg;
  assign busy  = (state_reg != IDLE);

`ifdef DROP_SCHED_STATS_EN
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  decision_t     dec_reg;
  logic [SW-1:0] pass_cnt_reg;
  logic [SW-1:0] drop_cnt_reg;
  logic          hs_issue;
  logic          hs_done;

  // The rails are already low by REL, so the decision is remembered
  // separately for crediting at handshake completion.
  assign hs_issue = (state_reg == IDLE) && (state_next == REQ);
  assign hs_done  = (state_reg == REL)  && !ack_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_reg      <= DEC_PASS;
      pass_cnt_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (hs_issue) begin
        dec_reg <= dec_pass ? DEC_PASS : DEC_DROP;
      end
      if (hs_done) begin
        if (dec_reg == DEC_PASS) begin
          if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + CNT_ONE;
        end else begin
          if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign pass_cnt = pass_cnt_reg;
  assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_drop_sched.sv
// tb_drop_sched
//   Self-checking bench for drop_sched. The main process sets up each
//   scenario and pushes the expected rail sequence into exp_q; a negedge
//   monitor acts as the 4-phase datapath responder, pops an expectation
//   on every new request and checks handshake ordering.
//   Build with DROP_SCHED_STATS_EN defined to include the statistics tests.
module tb_drop_sched;

  localparam int CW = 8;
  localparam int SS = 2;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          en       = 1'b0;
  logic [CW-1:0] pass_len = '0;
  logic [CW-1:0] drop_len = '0;
  logic          actl_i   = 1'b0;
  logic          ctl_a;
  logic          ctl_b;
  logic          busy;

`ifdef DROP_SCHED_STATS_EN
  localparam int SW = 2;
  logic [SW-1:0] pass_cnt;
  logic [SW-1:0] drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  bit exp_q[$];          // 0 = expect ctl_a, 1 = expect ctl_b
  int rises     = 0;     // requests observed
  int ack_delay = 0;     // responder delay in cycles
  logic prev_rail = 1'b0;
  int hi_cnt = 0;        // samples with rail high and ack high
  int lo_cnt = 100;      // samples with rail low and ack low
  int dly    = 0;

  always #5 clk = ~clk;

  drop_sched #(
    .CW          (CW),
    .SYNC_STAGES (SS)
`ifdef DROP_SCHED_STATS_EN
    ,
    .SW          (SW)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pass_len (pass_len),
    .drop_len (drop_len),
    .ctl_a    (ctl_a),
    .ctl_b    (ctl_b),
    .actl_i   (actl_i),
    .busy     (busy)
`ifdef DROP_SCHED_STATS_EN
    ,
    .pass_cnt (pass_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor + datapath responder.
  always @(negedge clk) begin
    logic rail;
    bit   d;
    if (!rst) begin
      prev_rail = 1'b0;
      actl_i    = 1'b0;
      hi_cnt    = 0;
      lo_cnt    = 100;
      dly       = 0;
    end else begin
      rail = ctl_a | ctl_b;
      if (rail) chk("one_hot", {31'b0, ctl_a & ctl_b}, 32'd0);
      if (rail && !prev_rail) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got a=%0d b=%0d expected no request", ctl_a, ctl_b);
        end else begin
          d = exp_q.pop_front();
          chk(d ? "req_rail_b" : "req_rail_a", {30'b0, ctl_a, ctl_b}, d ? 32'd1 : 32'd2);
        end
        chk("ack_low_at_req", {31'b0, actl_i}, 32'd0);
        chk("release_before_req", {31'b0, lo_cnt >= SS + 1}, 32'd1);
        rises++;
        hi_cnt = 0;
        dly    = 0;
      end
      if (!rail && prev_rail) begin
        chk("held_until_ack", {31'b0, hi_cnt >= SS}, 32'd1);
        dly = 0;
      end
      if (rail && actl_i) hi_cnt++;
      if (!rail && !actl_i) lo_cnt++;
      else lo_cnt = 0;
      if (rail != actl_i) begin
        if (dly >= ack_delay) begin
          actl_i = rail;
          dly    = 0;
        end else begin
          dly++;
        end
      end
      prev_rail = rail;
    end
  end

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input string s);
    foreach (s[i]) exp_q.push_back(s[i] == "b");
  endtask

  // Let exactly n requests issue, then drop en and wait for idle.
  task automatic run_n(input int n);
    int target;
    int t;
    target = rises + n;
    t = 0;
    en = 1'b1;
    while (rises < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    en = 1'b0;
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got %0d requests expected %0d", rises, target);
    end
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_after_run", {31'b0, busy}, 32'd0);
    chk("req_count", rises, target);
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int saved;

    // Reset state
    do_reset();
    chk("rst_ctl_a", {31'b0, ctl_a}, 32'd0);
    chk("rst_ctl_b", {31'b0, ctl_b}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
`ifdef DROP_SCHED_STATS_EN
    chk("rst_pass_cnt", pass_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
`endif

    // 2 pass / 1 drop, immediate ack; first request one cycle after en.
    pass_len = 8'd2;
    drop_len = 8'd1;
    ack_delay = 0;
    push("aabaab");
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("en_to_rail_latency", {31'b0, ctl_a}, 32'd1);
    run_n(6);

    // en=0 after the last request: no further requests, rails stay low.
    saved = rises;
    repeat (10) @(negedge clk);
    chk("no_req_when_disabled", rises, saved);
    chk("rails_low_when_disabled", {30'b0, ctl_a, ctl_b}, 32'd0);

    // Slow ack: rails held until synchronized ack, release ordering.
    do_reset();
    ack_delay = 5;
    push("aab");
    run_n(3);
    ack_delay = 0;

    // All dropped.
    do_reset();
    pass_len = 8'd0;
    drop_len = 8'd3;
    push("bbbb");
    run_n(4);

    // Both lengths zero: all passed, position stays at 0 so the next
    // config is loaded immediately.
    do_reset();
    pass_len = 8'd0;
    drop_len = 8'd0;
    push("aaa");
    run_n(3);
    pass_len = 8'd1;
    drop_len = 8'd1;
    push("ab");
    run_n(2);

    // Mid-period change: pass_len 2->4 at pos=1, resumed after en=0.
    do_reset();
    pass_len = 8'd2;
    drop_len = 8'd1;
    push("a");
    run_n(1);
    pass_len = 8'd4;
    push("abaaaab");
    run_n(7);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    pass_len = 8'd2;
    drop_len = 8'd1;
    ack_delay = 20;
    push("a");
    begin
      int t;
      int target;
      target = rises + 1;
      t = 0;
      en = 1'b1;
      while (rises < target && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("pre_rst_ctl_a", {31'b0, ctl_a}, 32'd1);
      rst = 1'b0;
      #1;
      chk("async_rst_ctl_a", {31'b0, ctl_a}, 32'd0);
      chk("async_rst_ctl_b", {31'b0, ctl_b}, 32'd0);
      chk("async_rst_busy", {31'b0, busy}, 32'd0);
      en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      ack_delay = 0;
    end

`ifdef DROP_SCHED_STATS_EN
    // Statistics and saturation (SW=2 saturates at 3).
    do_reset();
    pass_len = 8'd3;
    drop_len = 8'd1;
    push("aaab");
    run_n(4);
    chk("stats_pass_cnt", pass_cnt, 32'd3);
    chk("stats_drop_cnt", drop_cnt, 32'd1);
    push("aaab");
    run_n(4);
    chk("stats_pass_sat", pass_cnt, 32'd3);
    chk("stats_drop_cnt2", drop_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
